// File: rtl/stype_pkg.sv
// Shared constants, state encoding and field bundle
// for the S-type store instruction encoder.
package stype_pkg;

  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [11:0] imm;
  } sfields_t;

  function automatic logic f3_legal(
    input logic [2:0] f3
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (f3 == F3_SB): ok = 1'b1;
      (f3 == F3_SH): ok = 1'b1;
      (f3 == F3_SW): ok = 1'b1;
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/stype_field_pack.sv
// Combinational S-type field packer with
// store-width legality check.
module stype_field_pack
  import stype_pkg::*;
(
  input  sfields_t    f,
  output logic [31:0] instr,
  output logic        legal
);

  always_comb begin
    instr = {
      f.imm[11:5],
      f.rs2,
      f.rs1,
      f.funct3,
      f.imm[4:0],
      OPCODE_STORE
    };
    legal = f3_legal(f.funct3);
  end

endmodule

// File: rtl/st_encoder.sv
// S-type store encoder: valid/ready in, tagged
// instruction words out, sticky illegal-width error.
module st_encoder
  import stype_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [11:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic [31:0]      addr,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count
);

  state_t state, state_nxt;

  logic [31:0]      instr_q;
  logic [31:0]      addr_q;
  logic [31:0]      pc_q;
  logic [31:0]      pc_adv;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  sfields_t    fld;
  logic [31:0] pk_instr;
  logic        pk_legal;

  logic hs;
  logic ld;
  logic set_err;
  logic clr_err;

  assign fld = '{
    rs1:    rs1,
    rs2:    rs2,
    funct3: funct3,
    imm:    imm
  };

  stype_field_pack u_pack (
    .f     (fld),
    .instr (pk_instr),
    .legal (pk_legal)
  );

  assign out_valid = (state == ST_BUSY);
  assign hs        = out_valid & out_ready;

  // A word loaded alongside a handshake is tagged
  // with the already-advanced pc.
  assign pc_adv = hs ? pc_q + 32'd4 : pc_q;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ld        = 1'b0;
    set_err   = 1'b0;
    clr_err   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (pk_legal) begin
            ld        = 1'b1;
            state_nxt = ST_BUSY;
          end else begin
            set_err   = 1'b1;
            state_nxt = ST_ERR;
          end
        end
      end
      ST_BUSY: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (!in_valid) begin
            state_nxt = ST_IDLE;
          end else if (pk_legal) begin
            ld        = 1'b1;
            state_nxt = ST_BUSY;
          end else begin
            set_err   = 1'b1;
            state_nxt = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        if (err_clr) begin
          clr_err   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      instr_q <= '0;
      addr_q  <= BASE_ADDR;
      pc_q    <= BASE_ADDR;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_adv;
      if (ld) begin
        instr_q <= pk_instr;
        addr_q  <= pc_adv;
      end
      if (hs && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end else if (clr_err) begin
        err_q <= 1'b0;
      end
    end
  end

  assign instr = instr_q;
  assign addr  = addr_q;
  assign err   = err_q;
  assign count = cnt_q;

endmodule
